// File: rtl/weight_bram_sequencer.sv
// Shares one single-port weight BRAM between a random-write loader and sequential MAC read bursts.
// Optional statistics counters (burst_cnt, stall_cnt) are enabled with `define WEIGHT_SEQ_STATS_EN.
module weight_bram_sequencer #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ack,
    output logic          ld_err,
    input  logic          rd_start,
    input  logic          rd_stall,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] rd_idx,
    output logic          rd_last,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    output logic          bram_en,
    output logic          bram_we,
    input  logic [DW-1:0] bram_do
`ifdef WEIGHT_SEQ_STATS_EN
    ,
    output logic [15:0]   burst_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    // One extra bit so the range check stays meaningful even when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] idx;
    logic          start_pend;

    logic          ld_take;
    logic          ld_addr_bad;
    logic          issue_rd;
    logic          launch;

    assign ld_take     = (state == S_IDLE) && ld_req;
    assign ld_addr_bad = {1'b0, ld_addr} >= DEPTH_W;
    assign issue_rd    = (state == S_READ) && !rd_stall;
    // A pending burst starts from IDLE or directly out of DRAIN, but never ahead of the loader.
    assign launch      = (state != S_READ) && start_pend && !ld_req;

    // NOTE: every output of this block gets a value before any condition, so no latch is inferred.
    always_comb begin
        ld_ack    = ld_take;
        ld_err    = ld_take && ld_addr_bad;
        bram_we   = ld_take && !ld_addr_bad;
        bram_en   = (ld_take && !ld_addr_bad) || issue_rd;
        bram_addr = (state == S_READ) ? idx : ld_addr;
        bram_di   = ld_data;
    end

    assign rd_busy = start_pend || (state != S_IDLE);
    assign rd_data = bram_do;
    assign rd_last = rd_valid && (rd_idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            start_pend <= 1'b0;
            rd_valid   <= 1'b0;
            rd_idx     <= '0;
        end else begin
            rd_valid <= issue_rd;
            if (issue_rd) begin
                rd_idx <= idx;
            end

            // A new pulse in the launch cycle is kept as the next pending burst.
            if (rd_start) begin
                start_pend <= 1'b1;
            end else if (launch) begin
                start_pend <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= S_READ;
                        idx   <= '0;
                    end
                end
                S_READ: begin
                    if (issue_rd) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DRAIN;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (launch) begin
                        state <= S_READ;
                        idx   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WEIGHT_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            // DRAIN is reached only by a burst that issued all DEPTH reads.
            if (state == S_DRAIN) begin
                burst_cnt <= burst_cnt + 16'd1;
            end
            if ((state == S_READ) && rd_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
